// File: rtl/rom_port_arbiter.sv
// Two-port valid/ready arbiter sharing one combinational program ROM; registers the ROM word,
// flags misaligned/out-of-range accesses. Define ROM_PORT_ARBITER_RR_EN for round-robin, else fixed IF priority.
module rom_port_arbiter #(
    parameter int unsigned LENGTH = 32,
    parameter int unsigned WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             if_req_valid,
    output logic             if_req_ready,
    input  logic [WIDTH-1:0] if_req_addr,
    output logic             if_resp_valid,
    input  logic             if_resp_ready,
    output logic [WIDTH-1:0] if_resp_data,
    output logic             if_resp_err,

    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic [WIDTH-1:0] d_req_addr,
    output logic             d_resp_valid,
    input  logic             d_resp_ready,
    output logic [WIDTH-1:0] d_resp_data,
    output logic             d_resp_err,

    output logic [WIDTH-1:0] rom_address,
    input  logic [WIDTH-1:0] rom_instruction,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    localparam logic [WIDTH-1:0] LENGTH_W = WIDTH'(LENGTH);

    state_e           state_q, state_d;
    port_e            owner_q, owner_d;
    port_e            last_served_q, last_served_d;
    logic [WIDTH-1:0] rom_address_q, rom_address_d;
    logic [WIDTH-1:0] if_resp_data_q, if_resp_data_d;
    logic [WIDTH-1:0] d_resp_data_q, d_resp_data_d;
    logic             if_resp_err_q, if_resp_err_d;
    logic             d_resp_err_q, d_resp_err_d;

    logic             grant_if, grant_d;
    logic [WIDTH-1:0] req_addr;
    logic             req_err;
    logic             owner_resp_ready;
    logic             wr_en;
    port_e            wr_port;
    logic [WIDTH-1:0] wr_data;
    logic             wr_err;

    // Grant is only offered while idle; the loser simply keeps its request pending.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_q == IDLE) begin
`ifdef ROM_PORT_ARBITER_RR_EN
            if (if_req_valid && d_req_valid) begin
                grant_if = (last_served_q == PORT_D);
                grant_d  = (last_served_q == PORT_IF);
            end else begin
                grant_if = if_req_valid;
                grant_d  = d_req_valid;
            end
`else
            grant_if = if_req_valid;
            grant_d  = d_req_valid && !if_req_valid;
`endif
        end
    end

    always_comb begin
        req_addr = grant_d ? d_req_addr : if_req_addr;
        req_err  = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[WIDTH-1:2]} >= LENGTH_W);
    end

    assign owner_resp_ready = (owner_q == PORT_D) ? d_resp_ready : if_resp_ready;

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        rom_address_d = rom_address_q;
        wr_en         = 1'b0;
        wr_port       = owner_q;
        wr_data       = '0;
        wr_err        = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_if || grant_d) begin
                    owner_d       = grant_d ? PORT_D : PORT_IF;
                    last_served_d = grant_d ? PORT_D : PORT_IF;
                    if (req_err) begin
                        // Faulting access never touches the ROM; respond next cycle.
                        wr_en   = 1'b1;
                        wr_port = grant_d ? PORT_D : PORT_IF;
                        wr_data = '0;
                        wr_err  = 1'b1;
                        state_d = RESP;
                    end else begin
                        rom_address_d = req_addr;
                        state_d       = READ;
                    end
                end
            end
            READ: begin
                wr_en   = 1'b1;
                wr_port = owner_q;
                wr_data = rom_instruction;
                wr_err  = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (owner_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        if_resp_data_d = if_resp_data_q;
        if_resp_err_d  = if_resp_err_q;
        d_resp_data_d  = d_resp_data_q;
        d_resp_err_d   = d_resp_err_q;
        if (wr_en) begin
            if (wr_port == PORT_D) begin
                d_resp_data_d = wr_data;
                d_resp_err_d  = wr_err;
            end else begin
                if_resp_data_d = wr_data;
                if_resp_err_d  = wr_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            owner_q        <= PORT_IF;
            last_served_q  <= PORT_D;
            rom_address_q  <= '0;
            if_resp_data_q <= '0;
            if_resp_err_q  <= 1'b0;
            d_resp_data_q  <= '0;
            d_resp_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_served_q  <= last_served_d;
            rom_address_q  <= rom_address_d;
            if_resp_data_q <= if_resp_data_d;
            if_resp_err_q  <= if_resp_err_d;
            d_resp_data_q  <= d_resp_data_d;
            d_resp_err_q   <= d_resp_err_d;
        end
    end

    assign if_req_ready  = grant_if;
    assign d_req_ready   = grant_d;
    assign if_resp_valid = (state_q == RESP) && (owner_q == PORT_IF);
    assign d_resp_valid  = (state_q == RESP) && (owner_q == PORT_D);
    assign if_resp_data  = if_resp_data_q;
    assign if_resp_err   = if_resp_err_q;
    assign d_resp_data   = d_resp_data_q;
    assign d_resp_err    = d_resp_err_q;
    assign rom_address   = rom_address_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized bench for rom_port_arbiter against a transaction/latency-level reference model.
module tb_rom_port_arbiter;

    localparam int unsigned LENGTH = 32;
    localparam int unsigned WIDTH  = 32;

    logic             clk;
    logic             rst_n;
    logic             if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_resp_err;
    logic             d_req_valid, d_req_ready, d_resp_valid, d_resp_ready, d_resp_err;
    logic [WIDTH-1:0] if_req_addr, if_resp_data, d_req_addr, d_resp_data;
    logic [WIDTH-1:0] rom_address, rom_instruction;
    logic             busy;

    logic [31:0] rom_mem [0:LENGTH-1];

    rom_port_arbiter #(.LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
        .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
        .d_resp_data(d_resp_data), .d_resp_err(d_resp_err),
        .rom_address(rom_address), .rom_instruction(rom_instruction), .busy(busy)
    );

    always_comb rom_instruction = rom_mem[rom_address[6:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: one transaction in flight, response visible m_lat cycles after accept.
    bit          m_busy, m_owner, m_last;
    int          m_k, m_lat;
    logic [31:0] m_data [2];
    bit          m_err  [2];
    logic [31:0] m_pend_data, m_rom_addr;
    bit          m_pend_err;
    bit          acc_if, acc_d;
    int          grants_if, grants_d;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = 1; m_k = 0; m_lat = 0;
        m_data[0] = '0; m_data[1] = '0; m_err[0] = 0; m_err[1] = 0;
        m_rom_addr = '0; acc_if = 0; acc_d = 0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_rom_addr"}, rom_address, 0);
        check({pfx, "_if_valid"}, if_resp_valid, 0);
        check({pfx, "_d_valid"}, d_resp_valid, 0);
        check({pfx, "_if_data"}, if_resp_data, 0);
        check({pfx, "_d_data"}, d_resp_data, 0);
        check({pfx, "_if_err"}, if_resp_err, 0);
        check({pfx, "_d_err"}, d_resp_err, 0);
    endtask

    task automatic tick();
        bit e_if, e_d, vis, e_err;
        logic [31:0] a;
        @(negedge clk);
        e_if = 0; e_d = 0;
        if (!m_busy) begin
            if (if_req_valid && d_req_valid) begin
`ifdef ROM_PORT_ARBITER_RR_EN
                e_if = m_last;
`else
                e_if = 1;
`endif
                e_d = !e_if;
            end else begin
                e_if = if_req_valid;
                e_d  = d_req_valid;
            end
        end
        vis = m_busy && (m_k >= m_lat);
        check("if_req_ready", if_req_ready, e_if);
        check("d_req_ready", d_req_ready, e_d);
        check("busy", busy, m_busy);
        check("if_resp_valid", if_resp_valid, vis && !m_owner);
        check("d_resp_valid", d_resp_valid, vis && m_owner);
        check("rom_address", rom_address, m_rom_addr);
        check("if_resp_data", if_resp_data, m_data[0]);
        check("if_resp_err", if_resp_err, m_err[0]);
        check("d_resp_data", d_resp_data, m_data[1]);
        check("d_resp_err", d_resp_err, m_err[1]);

        acc_if = 0; acc_d = 0;
        if (m_busy) begin
            if (vis && (m_owner ? d_resp_ready : if_resp_ready)) begin
                m_busy = 0;
            end else begin
                m_k++;
                if (m_k == m_lat) begin
                    m_data[m_owner] = m_pend_data;
                    m_err[m_owner]  = m_pend_err;
                end
            end
        end else if (e_if || e_d) begin
            a           = e_d ? d_req_addr : if_req_addr;
            e_err       = (a % 4 != 0) || (a / 4 >= LENGTH);
            m_owner     = e_d;
            m_last      = e_d;
            m_busy      = 1;
            m_lat       = e_err ? 1 : 2;
            m_pend_err  = e_err;
            m_pend_data = e_err ? 32'h0 : rom_mem[a / 4];
            if (!e_err) m_rom_addr = a;
            m_k = 1;
            if (m_k == m_lat) begin
                m_data[m_owner] = m_pend_data;
                m_err[m_owner]  = m_pend_err;
            end
            acc_if = e_if; acc_d = e_d;
            if (e_d) grants_d++; else grants_if++;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gen_addr();
        int unsigned r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r <= 5)      a = 32'($urandom_range(0, LENGTH - 1)) << 2;
        else if (r <= 7) a = (32'($urandom_range(0, LENGTH - 1)) << 2) | 32'($urandom_range(1, 3));
        else if (r == 8) a = 32'(LENGTH * 4) + (32'($urandom_range(0, 7)) << 2);
        else             a = $urandom;
        return a;
    endfunction

    task automatic drain(input int n);
        if_req_valid = 0; d_req_valid = 0; if_resp_ready = 1; d_resp_ready = 1;
        repeat (n) tick();
    endtask

    initial begin
        for (int i = 0; i < int'(LENGTH); i++) rom_mem[i] = $urandom;
        rom_mem[2] = 32'h00A00093;
        rst_n = 0;
        if_req_valid = 0; if_req_addr = '0; if_resp_ready = 0;
        d_req_valid = 0;  d_req_addr = '0;  d_resp_ready = 0;
        model_reset();
        grants_if = 0; grants_d = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1;
        @(posedge clk); #1;

        // Good fetch: accept now, response two cycles later.
        if_req_valid = 1; if_req_addr = 32'h8; if_resp_ready = 1;
        #1;
        check("t1_if_ready", if_req_ready, 1);
        tick();
        if_req_valid = 0;
        tick();
        check("t1_if_valid", if_resp_valid, 1);
        check("t1_if_data", if_resp_data, 32'h00A00093);
        check("t1_if_err", if_resp_err, 0);
        check("t1_d_valid", d_resp_valid, 0);
        tick();

        // Misaligned and past-the-end data reads: one-cycle error response.
        d_req_valid = 1; d_req_addr = 32'h6; d_resp_ready = 1;
        tick();
        d_req_valid = 0;
        check("t2_mis_valid", d_resp_valid, 1);
        check("t2_mis_data", d_resp_data, 0);
        check("t2_mis_err", d_resp_err, 1);
        tick();
        d_req_valid = 1; d_req_addr = 32'h80;
        tick();
        d_req_valid = 0;
        check("t2_oor_valid", d_resp_valid, 1);
        check("t2_oor_err", d_resp_err, 1);
        tick();

        // Both ports continuously requesting.
        grants_if = 0; grants_d = 0;
        if_req_valid = 1; if_req_addr = 32'h0; d_req_valid = 1; d_req_addr = 32'h4;
        if_resp_ready = 1; d_resp_ready = 1;
        repeat (12) tick();
`ifdef ROM_PORT_ARBITER_RR_EN
        check("t3_rr_d_grants", grants_d, 2);
        check("t3_rr_balance", (grants_if >= grants_d) && (grants_if - grants_d <= 1), 1);
`else
        check("t3_fix_d_grants", grants_d, 0);
        check("t3_fix_if_grants", grants_if, 4);
`endif
        drain(4);

        // Stall the fetch response; the pending data request must wait for the handshake.
        if_req_valid = 1; if_req_addr = 32'h10; if_resp_ready = 0;
        tick();
        if_req_valid = 0; d_req_valid = 1; d_req_addr = 32'h14; d_resp_ready = 1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid", if_resp_valid, 1);
            check("t4_hold_data", if_resp_data, rom_mem[4]);
            check("t4_hold_dready", d_req_ready, 0);
            tick();
        end
        if_resp_ready = 1;
        tick();
        tick();
        check("t4_d_granted", acc_d, 1);
        d_req_valid = 0;
        drain(3);

        // Reset in the READ cycle.
        if_req_valid = 1; if_req_addr = 32'hC; if_resp_ready = 1;
        tick();
        check("t5_in_read", busy, 1);
        rst_n = 0;
        #1;
        check_reset_outputs("t5_midreset");
        if_req_valid = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        repeat (3) tick();
        d_req_valid = 1; d_req_addr = 32'h1C; d_resp_ready = 1;
        tick();
        d_req_valid = 0;
        tick();
        check("t5_post_valid", d_resp_valid, 1);
        check("t5_post_data", d_resp_data, rom_mem[7]);
        drain(2);

        // Random traffic; requesters hold valid/addr until accepted.
        for (int i = 0; i < 600; i++) begin
            if (!if_req_valid || acc_if) begin
                if_req_valid = ($urandom_range(0, 2) != 0);
                if_req_addr  = gen_addr();
            end
            if (!d_req_valid || acc_d) begin
                d_req_valid = ($urandom_range(0, 2) != 0);
                d_req_addr  = gen_addr();
            end
            if_resp_ready = ($urandom_range(0, 3) != 0);
            d_resp_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
